uart_alu_cmd_sequencer: RTL and testbench
=========================================

# uart_alu_cmd_sequencer

Frame-based command controller between the UART receiver/transmitter and the ALU. It parses fixed 3-byte command frames from the RX byte stream, loads the ALU operand and opcode registers, and triggers an execute. It returns an acknowledge byte, plus the ALU result on execute, through the TX start/done handshake. It replaces ad-hoc byte counting with a framed, timeout-protected protocol and an error counter.

## Interface
- NB_DATA, 8, UART byte and ALU operand width
- NB_ALU_OP, 6, ALU opcode width
- NB_TIMEOUT, 16, inter-byte timeout counter width
- TIMEOUT_CYCLES, 50000, max clocks between frame bytes before abort
- SYNC_BYTE, 8'hA5, frame start marker
- ACK_BYTE, 8'h5A, positive response
- ERR_BYTE, 8'hEE, unknown-command response
- i_clk  in  1  single system clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse per received byte
- i_tx_done  in  1  one-cycle pulse when the transmitter finishes a byte
- i_alu_res  in  NB_DATA  combinational ALU result of o_alu_a/o_alu_b/o_alu_op
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_tx_data  out  NB_DATA  byte to transmit, held stable until i_tx_done
- o_alu_op  out  NB_ALU_OP  registered opcode
- o_alu_a, o_alu_b  out  NB_DATA  registered operands
- o_busy  out  1  high in any state other than IDLE
- o_err_cnt  out  8  saturating error count (unknown cmd + timeouts)

## Operation
- Frame: SYNC, CMD, ARG. CMD 8'h01 A<=ARG; 8'h02 B<=ARG; 8'h03 OP<=ARG[NB_ALU_OP-1:0]; 8'h04 execute (ARG ignored but required).
- States: IDLE, GET_CMD, GET_ARG, EXEC, SEND_HDR, WAIT_HDR, SEND_RES, WAIT_RES.
- IDLE: rx byte == SYNC_BYTE -> GET_CMD; any other byte is dropped silently, no error.
- GET_CMD: rx byte stored as cmd -> GET_ARG.
- GET_ARG on rx byte: write cmds update the register and go to SEND_HDR with tx byte ACK; cmd 04 -> EXEC; unknown cmd -> SEND_HDR with ERR_BYTE, err_cnt+1. No register changes on an unknown cmd.
- EXEC: one cycle; latches i_alu_res into result register -> SEND_HDR (ACK).
- SEND_HDR: o_tx_start=1 for exactly one cycle -> WAIT_HDR. WAIT_HDR on i_tx_done: execute -> SEND_RES (result byte), else -> IDLE.
- SEND_RES/WAIT_RES: same handshake with the result byte -> IDLE.
- Timeout: counter runs only in GET_CMD/GET_ARG; clears on entering them and on each accepted byte; reaching TIMEOUT_CYCLES -> IDLE, err_cnt+1, no response.
- Bytes arriving in EXEC/SEND_*/WAIT_* are discarded (no buffering).
- err_cnt saturates at 255. Simultaneous unknown-cmd and timeout is impossible, because the byte wins: an rx byte in the timeout cycle is accepted.
- Reset (any time, including mid-frame or mid-TX): state IDLE; o_alu_a/b/op=0; result=0; o_tx_start=0; o_tx_data=0; o_busy=0; o_err_cnt=0; timeout counter 0.

## Timing
- Inputs sampled on the rising edge of i_clk; all outputs registered.
- Write cmd: ARG rx_done at edge N -> register updated and state SEND_HDR after N; o_tx_start high in cycle N+1.
- Execute: ARG at edge N -> EXEC cycle N+1, result latched at its end; o_tx_start (ACK) in cycle N+2; result o_tx_start one cycle after the i_tx_done for ACK.
- o_tx_data valid from the o_tx_start cycle until i_tx_done; o_tx_start never asserts while waiting.
- i_tx_done outside WAIT_* is ignored.
- Operands and opcode stay constant from EXEC until the next write command.

## Structure
- Shared package uart_alu_pkg: state enum, CMD_WR_A/CMD_WR_B/CMD_WR_OP/CMD_EXEC localparams, default SYNC/ACK/ERR bytes.
- One natural sub-module: timeout_counter (clear, enable, terminal-count pulse), parameterised by NB_TIMEOUT/TIMEOUT_CYCLES.

## Test plan
- Frames A5 01 07, A5 02 03, A5 03 20, A5 04 00 with ALU model add -> ACK byte per write; execute returns 5A then 0A; o_alu_a=07, o_alu_b=03, o_alu_op=20.
- Junk 11 22 then A5 01 FF -> junk ignored, err_cnt stays 0, A=FF, one ACK.
- A5 09 00 -> single EE byte, err_cnt=1, A/B/OP unchanged.
- A5 01 then silence > TIMEOUT_CYCLES (bench uses 100) -> back to IDLE, no tx_start, err_cnt+1; next A5 02 04 works normally.
- Bytes sent during WAIT_RES, and i_tx_done held off 500 cycles -> extra bytes dropped, no second tx_start, o_tx_data stable.
- i_rst_n low mid-frame and during WAIT_HDR -> all outputs at reset values immediately; 256 forced errors -> o_err_cnt=FF.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU command sequencer: FSM state codes,
// command opcodes and default protocol bytes.
package uart_alu_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_GET_CMD  = 3'd1;
    localparam state_t ST_GET_ARG  = 3'd2;
    localparam state_t ST_EXEC     = 3'd3;
    localparam state_t ST_SEND_HDR = 3'd4;
    localparam state_t ST_WAIT_HDR = 3'd5;
    localparam state_t ST_SEND_RES = 3'd6;
    localparam state_t ST_WAIT_RES = 3'd7;

    localparam logic [7:0] CMD_WR_A  = 8'h01;
    localparam logic [7:0] CMD_WR_B  = 8'h02;
    localparam logic [7:0] CMD_WR_OP = 8'h03;
    localparam logic [7:0] CMD_EXEC  = 8'h04;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ACK_BYTE  = 8'h5A;
    localparam logic [7:0] DEF_ERR_BYTE  = 8'hEE;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// o_tc on the TIMEOUT_CYCLES-th one.
module timeout_counter #(
    parameter int unsigned NB_TIMEOUT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [NB_TIMEOUT-1:0] TC_VAL = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;

    always_comb begin
        o_tc  = i_enable && !i_clear && (cnt_q == TC_VAL);
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = o_tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_cmd_sequencer.sv
// Parses SYNC/CMD/ARG frames from the UART receiver, drives the ALU operand
// registers and returns ACK/ERR (plus the result on execute) via the transmitter.
module uart_alu_cmd_sequencer
    import uart_alu_pkg::*;
#(
    parameter int unsigned         NB_DATA        = 8,
    parameter int unsigned         NB_ALU_OP      = 6,
    parameter int unsigned         NB_TIMEOUT     = 16,
    parameter int unsigned         TIMEOUT_CYCLES = 50000,
    parameter logic [NB_DATA-1:0]  SYNC_BYTE      = NB_DATA'(DEF_SYNC_BYTE),
    parameter logic [NB_DATA-1:0]  ACK_BYTE       = NB_DATA'(DEF_ACK_BYTE),
    parameter logic [NB_DATA-1:0]  ERR_BYTE       = NB_DATA'(DEF_ERR_BYTE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_alu_res,
    output logic                 o_tx_start,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic [NB_ALU_OP-1:0] o_alu_op,
    output logic [NB_DATA-1:0]   o_alu_a,
    output logic [NB_DATA-1:0]   o_alu_b,
    output logic                 o_busy,
    output logic [7:0]           o_err_cnt
);

    state_t                 state_q, state_d;
    logic [NB_DATA-1:0]     cmd_q, cmd_d;
    logic [NB_DATA-1:0]     alu_a_q, alu_a_d;
    logic [NB_DATA-1:0]     alu_b_q, alu_b_d;
    logic [NB_ALU_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_DATA-1:0]     result_q, result_d;
    logic                   tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
    logic                   busy_q, busy_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic in_frame;
    logic timeout;

    assign in_frame = (state_q == ST_GET_CMD) || (state_q == ST_GET_ARG);

    // Any accepted byte restarts the watchdog; outside the frame it is held clear.
    timeout_counter #(
        .NB_TIMEOUT     (NB_TIMEOUT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (i_rx_done || !in_frame),
        .i_enable (in_frame),
        .o_tc     (timeout)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        result_d   = result_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done && (i_rx_data == SYNC_BYTE)) state_d = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (i_rx_done) begin
                    cmd_d   = i_rx_data;
                    state_d = ST_GET_ARG;
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
            ST_GET_ARG: begin
                if (i_rx_done) begin
                    state_d    = ST_SEND_HDR;
                    tx_start_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                    if (cmd_q == NB_DATA'(CMD_WR_A)) begin
                        alu_a_d = i_rx_data;
                    end else if (cmd_q == NB_DATA'(CMD_WR_B)) begin
                        alu_b_d = i_rx_data;
                    end else if (cmd_q == NB_DATA'(CMD_WR_OP)) begin
                        alu_op_d = i_rx_data[NB_ALU_OP-1:0];
                    end else if (cmd_q == NB_DATA'(CMD_EXEC)) begin
                        state_d    = ST_EXEC;
                        tx_start_d = 1'b0;
                        tx_data_d  = tx_data_q;
                    end else begin
                        tx_data_d = ERR_BYTE;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                end else if (timeout) begin
                    state_d   = ST_IDLE;
                    err_cnt_d = sat_inc(err_cnt_q);
                end
            end
            ST_EXEC: begin
                result_d   = i_alu_res;
                state_d    = ST_SEND_HDR;
                tx_start_d = 1'b1;
                tx_data_d  = ACK_BYTE;
            end
            ST_SEND_HDR: state_d = ST_WAIT_HDR;
            ST_WAIT_HDR: begin
                if (i_tx_done) begin
                    if (cmd_q == NB_DATA'(CMD_EXEC)) begin
                        state_d    = ST_SEND_RES;
                        tx_start_d = 1'b1;
                        tx_data_d  = result_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SEND_RES: state_d = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (i_tx_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            result_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            result_q   <= result_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_alu_op   = alu_op_q;
    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_busy     = busy_q;
    assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_alu_cmd_sequencer.sv
// Scoreboard bench: frames are modelled at the protocol level, expected TX
// bytes queued, and a monitor checks every transmitted byte.
module tb_uart_alu_cmd_sequencer;

    localparam int unsigned TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] alu_res;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [5:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       busy;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        logic [7:0] r;
        case (op)
            6'h20:   r = a + b;
            6'h22:   r = a - b;
            6'h24:   r = a & b;
            6'h25:   r = a | b;
            6'h26:   r = a ^ b;
            6'h27:   r = ~(a | b);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_op);

    uart_alu_cmd_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .i_tx_done  (tx_done),
        .i_alu_res  (alu_res),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .o_alu_op   (alu_op),
        .o_alu_a    (alu_a),
        .o_alu_b    (alu_b),
        .o_busy     (busy),
        .o_err_cnt  (err_cnt)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    bit         pending = 0;
    logic [7:0] held = 8'h00;
    int         n_starts = 0;
    int         tx_delay = 2;

    // Reference model state
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [5:0] m_op = 6'h00;
    logic [7:0] m_err = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_start and checks data stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 0;
        end else begin
            if (pending && tx_done) begin
                check("tx_data_stable", {24'h0, tx_data}, {24'h0, held});
                pending = 0;
            end
            if (tx_start) begin
                n_starts++;
                if (pending) begin
                    check("tx_start_while_waiting", 32'd1, 32'd0);
                end else if (exp_q.size() == 0) begin
                    check("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                    held    = tx_data;
                    pending = 1;
                end
            end
        end
    end

    // Transmitter model: acknowledges each started byte after tx_delay cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                repeat (tx_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] cmd, input logic [7:0] arg);
        case (cmd)
            8'h01: begin m_a = arg; exp_q.push_back(8'h5A); end
            8'h02: begin m_b = arg; exp_q.push_back(8'h5A); end
            8'h03: begin m_op = arg[5:0]; exp_q.push_back(8'h5A); end
            8'h04: begin
                exp_q.push_back(8'h5A);
                exp_q.push_back(alu_f(m_a, m_b, m_op));
            end
            default: begin
                exp_q.push_back(8'hEE);
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end
        endcase
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] arg);
        model_frame(cmd, arg);
        send_byte(8'hA5);
        gap($urandom_range(0, 4));
        send_byte(cmd);
        gap($urandom_range(0, 4));
        send_byte(arg);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && !pending && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("idle_reached", {31'h0, ok}, 32'd1);
    endtask

    task automatic wait_starts(input int target);
        for (int i = 0; i < 2000; i++) begin
            if (n_starts >= target) break;
            @(negedge clk);
        end
        check("tx_start_seen", {31'h0, n_starts >= target}, 32'd1);
    endtask

    task automatic check_regs();
        check("alu_a", {24'h0, alu_a}, {24'h0, m_a});
        check("alu_b", {24'h0, alu_b}, {24'h0, m_b});
        check("alu_op", {26'h0, alu_op}, {26'h0, m_op});
        check("err_cnt", {24'h0, err_cnt}, {24'h0, m_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, {31'h0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'd0);
        check({tag, "_alu_a"}, {24'h0, alu_a}, 32'd0);
        check({tag, "_alu_b"}, {24'h0, alu_b}, 32'd0);
        check({tag, "_alu_op"}, {26'h0, alu_op}, 32'd0);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_err_cnt"}, {24'h0, err_cnt}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        rx_done = 1'b0;
        #1 check_reset_outputs(tag);
        m_a = 8'h00;
        m_b = 8'h00;
        m_op = 6'h00;
        m_err = 8'h00;
        exp_q.delete();
        gap(3);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] j;
        int         r;
        int         base;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic register loads and execute with the add opcode
        send_frame(8'h01, 8'h07); wait_idle(); check_regs();
        send_frame(8'h02, 8'h03); wait_idle(); check_regs();
        send_frame(8'h03, 8'h20); wait_idle(); check_regs();
        send_frame(8'h04, 8'h00); wait_idle(); check_regs();

        // Junk before a frame is dropped without error
        send_byte(8'h11);
        send_byte(8'h22);
        send_frame(8'h01, 8'hFF); wait_idle(); check_regs();

        // Unknown command
        send_frame(8'h09, 8'h00); wait_idle(); check_regs();

        // Timeout in GET_ARG, then a normal frame
        send_byte(8'hA5);
        send_byte(8'h01);
        gap(TMO + 50);
        @(negedge clk);
        check("timeout_busy", {31'h0, busy}, 32'd0);
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        check_regs();
        send_frame(8'h02, 8'h04); wait_idle(); check_regs();

        // Bytes during WAIT_RES with a slow transmitter are dropped
        tx_delay = 500;
        base = n_starts;
        send_frame(8'h04, 8'h00);
        wait_starts(base + 2);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h33);
        wait_idle();
        check_regs();
        tx_delay = 2;

        // Randomised frames
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                j = 8'($urandom_range(0, 255));
                if (j == 8'hA5) j = 8'h00;
                send_byte(j);
            end
            r = $urandom_range(0, 5);
            if (r < 4) cmd = 8'(r + 1);
            else if (r == 4) cmd = 8'($urandom_range(5, 255));
            else cmd = 8'h00;
            tx_delay = $urandom_range(1, 6);
            send_frame(cmd, 8'($urandom_range(0, 255)));
            wait_idle();
            check_regs();
        end
        tx_delay = 2;

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h02);
        do_reset("rst_midframe");
        send_frame(8'h01, 8'h5C); wait_idle(); check_regs();

        // Reset while waiting for the ACK to finish
        tx_delay = 60;
        base = n_starts;
        send_frame(8'h04, 8'h00);
        wait_starts(base + 1);
        gap(5);
        do_reset("rst_waithdr");
        gap(80);
        tx_delay = 2;
        send_frame(8'h02, 8'h77); wait_idle(); check_regs();

        // Saturate the error counter
        tx_delay = 1;
        for (int k = 0; k < 256; k++) begin
            send_frame(8'hC3, 8'($urandom_range(0, 255)));
            wait_idle();
        end
        check("err_cnt_sat", {24'h0, err_cnt}, 32'h0000_00FF);
        send_frame(8'h10, 8'h00); wait_idle(); check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
